// File: rtl/instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable
//   Loadable instruction memory for the IF stage of the pipelined MIPS core.
//   A load port writes program words at run time. A req/ready/valid fetch port
//   returns one word per accepted request after WAIT_STATES extra cycles, and
//   can hold the result while the downstream stage stalls. Misaligned or
//   out-of-range fetch addresses return DEFAULT_INSTR with fetch_fault set.
//
// Ports
//   clk          in   core clock, rising edge
//   reset        in   asynchronous, active-low
//   load_mode    in   1 closes the fetch port (fetch_ready=0)
//   ld_we        in   load write strobe
//   ld_addr      in   load word index   [DEPTH_LOG2-1:0]
//   ld_data      in   load word         [31:0]
//   fetch_req    in   fetch request
//   fetch_addr   in   fetch byte address [31:0]
//   fetch_stall  in   downstream stall, holds a completed result
//   fetch_ready  out  request accepted on a rising edge when fetch_req & fetch_ready
//   instr        out  fetched instruction [31:0]
//   instr_valid  out  instr / fetch_fault are valid
//   fetch_fault  out  accepted address was misaligned or out of range
// -----------------------------------------------------------------------------
module instr_mem_loadable #(
   parameter int unsigned DEPTH_LOG2    = 8,
   parameter int unsigned WAIT_STATES   = 0,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter logic [31:0] DEFAULT_INSTR = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_mode,
   input  logic                  ld_we,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_data,
   input  logic                  fetch_req,
   input  logic [31:0]           fetch_addr,
   input  logic                  fetch_stall,
   output logic                  fetch_ready,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   output logic                  fetch_fault
);

   localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [1:0]  WS_LOAD = 2'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [31:0]             instr_q, instr_d;
   logic                    fault_q, fault_d;
   logic [31:0]             hold_instr_q, hold_instr_d;
   logic                    hold_fault_q, hold_fault_d;
   logic [DEPTH-1:0]        loaded_q, loaded_d;
   logic [31:0]             mem_q [DEPTH];

   logic [31:0]             offset;
   logic [DEPTH_LOG2-1:0]   rd_idx;
   logic                    rd_fault;
   logic [31:0]             rd_word;
   logic                    port_open;
   logic                    accept;

   // Address decode and array read. The array is read combinationally with the
   // current contents, so a same-edge load to the same index returns the old word.
   always_comb begin
      offset   = fetch_addr - BASE_ADDR;
      rd_idx   = offset[DEPTH_LOG2+1:2];
      rd_fault = (fetch_addr[1:0] != 2'b00)
              || (fetch_addr < BASE_ADDR)
              || ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);
      rd_word  = (!rd_fault && loaded_q[rd_idx]) ? mem_q[rd_idx] : DEFAULT_INSTR;
   end

   always_comb begin
      loaded_d = loaded_q;
      if (ld_we) loaded_d[ld_addr] = 1'b1;
   end

   // NOTE: the array itself has no reset; only the per-word loaded bits are
   // cleared, which is what makes unloaded words read as DEFAULT_INSTR.
   always_ff @(posedge clk) begin
      if (ld_we) mem_q[ld_addr] <= ld_data;
   end

   // Fetch FSM, next-state and outputs.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      instr_d      = instr_q;
      fault_d      = fault_q;
      hold_instr_d = hold_instr_q;
      hold_fault_d = hold_fault_q;
      fetch_ready  = 1'b0;
      instr_valid  = 1'b0;

      // Keep the port closed while reset is held so nothing looks acceptable.
      port_open = reset && !load_mode;

      case (state_q)
         S_IDLE: fetch_ready = port_open;
         S_WAIT: begin
            if (cnt_q == 2'd1) begin
               state_d = S_DONE;
               instr_d = hold_instr_q;
               fault_d = hold_fault_q;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_DONE: begin
            instr_valid = 1'b1;
            if (!fetch_stall) begin
               fetch_ready = port_open;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      accept = fetch_req && fetch_ready;
      if (accept) begin
         if (WAIT_STATES == 0) begin
            // Zero wait states: the accept edge is also the DONE entry.
            state_d = S_DONE;
            instr_d = rd_word;
            fault_d = rd_fault;
         end else begin
            state_d      = S_WAIT;
            cnt_d        = WS_LOAD;
            hold_instr_d = rd_word;
            hold_fault_d = rd_fault;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         instr_q      <= DEFAULT_INSTR;
         fault_q      <= 1'b0;
         hold_instr_q <= DEFAULT_INSTR;
         hold_fault_q <= 1'b0;
         loaded_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         instr_q      <= instr_d;
         fault_q      <= fault_d;
         hold_instr_q <= hold_instr_d;
         hold_fault_q <= hold_fault_d;
         loaded_q     <= loaded_d;
      end
   end

   assign instr       = instr_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loadable
//   Three instances share clock, reset and the load port:
//     inst 0: WAIT_STATES=0, BASE_ADDR=0
//     inst 1: WAIT_STATES=2, BASE_ADDR=0x100
//     inst 2: WAIT_STATES=3, BASE_ADDR=0
//   Each has its own fetch port. Expected words come from an array model of
//   the memory plus loaded flags, updated by the bench's own load/reset tasks.
// -----------------------------------------------------------------------------
module tb_instr_mem_loadable;

   localparam int          N     = 3;
   localparam int          WORDS = 256;
   localparam int          WS_TAB   [N] = '{0, 2, 3};
   localparam logic [31:0] BASE_TAB [N] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0000};
   localparam logic [31:0] DEF   = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ld_we = 1'b0;
   logic [7:0]    ld_addr = '0;
   logic [31:0]   ld_data = '0;
   logic [N-1:0]  load_mode = '0;
   logic [N-1:0]  fetch_req = '0;
   logic [N-1:0]  fetch_stall = '0;
   logic [31:0]   fetch_addr [N];
   logic [N-1:0]  fetch_ready;
   logic [N-1:0]  instr_valid;
   logic [N-1:0]  fetch_fault;
   logic [31:0]   instr [N];

   logic [31:0]   ref_mem    [WORDS];
   bit            ref_loaded [WORDS];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      instr_mem_loadable #(
         .DEPTH_LOG2    (8),
         .WAIT_STATES   (WS_TAB[g]),
         .BASE_ADDR     (BASE_TAB[g]),
         .DEFAULT_INSTR (DEF)
      ) u_dut (
         .clk         (clk),
         .reset       (reset),
         .load_mode   (load_mode[g]),
         .ld_we       (ld_we),
         .ld_addr     (ld_addr),
         .ld_data     (ld_data),
         .fetch_req   (fetch_req[g]),
         .fetch_addr  (fetch_addr[g]),
         .fetch_stall (fetch_stall[g]),
         .fetch_ready (fetch_ready[g]),
         .instr       (instr[g]),
         .instr_valid (instr_valid[g]),
         .fetch_fault (fetch_fault[g])
      );
   end

   // Reference: what a fetch of addr on instance g must return.
   function automatic void model(input int g, input logic [31:0] addr,
                                 output logic [31:0] w, output logic f);
      int unsigned off;
      w = DEF;
      f = 1'b0;
      if ((addr % 4) != 0 || addr < BASE_TAB[g]) begin
         f = 1'b1;
      end else begin
         off = (addr - BASE_TAB[g]) / 4;
         if (off >= WORDS) f = 1'b1;
         else if (ref_loaded[off]) w = ref_mem[off];
      end
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < WORDS; i++) ref_loaded[i] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic do_load(input int idx, input logic [31:0] data);
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = 8'(idx);
      ld_data = data;
      @(posedge clk);
      #1;
      ld_we = 1'b0;
      ref_mem[idx]    = data;
      ref_loaded[idx] = 1'b1;
   endtask

   // Issue one fetch and wait for its result; lat counts falling edges from the
   // accept edge to the first one where instr_valid is seen (WAIT_STATES+1).
   task automatic run_fetch(input int g, input logic [31:0] addr,
                            output logic [31:0] w, output logic f, output int lat);
      int n;
      @(negedge clk);
      fetch_req[g]  = 1'b1;
      fetch_addr[g] = addr;
      #1;
      n = 0;
      while (!fetch_ready[g] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      lat = -1;
      if (fetch_ready[g]) begin
         @(posedge clk);
         #1;
         fetch_req[g] = 1'b0;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!instr_valid[g] && lat < 12);
         if (!instr_valid[g]) lat = -1;
      end
      fetch_req[g] = 1'b0;
      w = instr[g];
      f = fetch_fault[g];
   endtask

   task automatic test_reset();
      #1;
      for (int g = 0; g < N; g++) begin
         checks++;
         if (instr[g] !== DEF) begin
            errors++; $display("FAIL reset_instr[%0d]: got %h want %h", g, instr[g], DEF);
         end
         checks++;
         if (instr_valid[g] !== 1'b0) begin
            errors++; $display("FAIL reset_valid[%0d]: got %b want 0", g, instr_valid[g]);
         end
         checks++;
         if (fetch_fault[g] !== 1'b0) begin
            errors++; $display("FAIL reset_fault[%0d]: got %b want 0", g, fetch_fault[g]);
         end
         checks++;
         if (fetch_ready[g] !== 1'b0) begin
            errors++; $display("FAIL reset_ready[%0d]: got %b want 0", g, fetch_ready[g]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int g = 0; g < N; g++) begin
         checks++;
         if (fetch_ready[g] !== 1'b1) begin
            errors++; $display("FAIL idle_ready[%0d]: got %b want 1", g, fetch_ready[g]);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] w, ew;
      logic        f, ef;
      int          lat;
      bit          seen;
      do_load(0, 32'hCAFE_0001);
      model(1, 32'h100, ew, ef);
      run_fetch(1, 32'h100, w, f, lat);
      checks++;
      if (w !== ew || lat != WS_TAB[1] + 1) begin
         errors++; $display("FAIL pre_reset_fetch: got %h lat %0d want %h lat %0d", w, lat, ew, WS_TAB[1] + 1);
      end
      // Start a second fetch and drop reset while it sits in WAIT.
      @(negedge clk);
      fetch_req[1]  = 1'b1;
      fetch_addr[1] = 32'h100;
      @(posedge clk);
      #2;
      fetch_req[1] = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < WORDS; i++) ref_loaded[i] = 1'b0;
      #1;
      checks++;
      if (instr[1] !== DEF) begin
         errors++; $display("FAIL mid_reset_instr: got %h want %h", instr[1], DEF);
      end
      checks++;
      if (instr_valid[1] !== 1'b0) begin
         errors++; $display("FAIL mid_reset_valid: got %b want 0", instr_valid[1]);
      end
      checks++;
      if (fetch_ready[1] !== 1'b0) begin
         errors++; $display("FAIL mid_reset_ready: got %b want 0", fetch_ready[1]);
      end
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (instr_valid[1]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL dropped_fetch: got valid=1 want valid=0");
      end
   endtask

   task automatic test_unloaded();
      logic [31:0] w, ew;
      logic        f, ef;
      int          lat;
      // The array keeps 0x12345678 at index 4 across reset, but the word is unloaded.
      do_load(4, 32'h1234_5678);
      do_reset();
      model(0, 32'h10, ew, ef);
      run_fetch(0, 32'h10, w, f, lat);
      checks++;
      if (w !== ew || f !== ef) begin
         errors++; $display("FAIL unloaded: got %h/%b want %h/%b", w, f, ew, ef);
      end
   endtask

   task automatic test_load_run();
      logic [31:0] ew0, ew1;
      logic        ef0, ef1;
      do_load(0, 32'h0800_0003);
      do_load(3, 32'h3c01_4000);
      model(0, 32'h0, ew0, ef0);
      model(0, 32'hC, ew1, ef1);
      @(negedge clk);
      fetch_req[0]  = 1'b1;
      fetch_addr[0] = 32'h0;
      #1;
      checks++;
      if (fetch_ready[0] !== 1'b1) begin
         errors++; $display("FAIL b2b_ready0: got %b want 1", fetch_ready[0]);
      end
      @(negedge clk);
      fetch_addr[0] = 32'hC;
      #1;
      checks++;
      if (instr_valid[0] !== 1'b1 || instr[0] !== ew0 || fetch_fault[0] !== ef0) begin
         errors++; $display("FAIL b2b_word0: got %b/%h/%b want 1/%h/%b",
                            instr_valid[0], instr[0], fetch_fault[0], ew0, ef0);
      end
      checks++;
      if (fetch_ready[0] !== 1'b1) begin
         errors++; $display("FAIL b2b_ready1: got %b want 1", fetch_ready[0]);
      end
      @(negedge clk);
      fetch_req[0] = 1'b0;
      #1;
      checks++;
      if (instr_valid[0] !== 1'b1 || instr[0] !== ew1 || fetch_fault[0] !== ef1) begin
         errors++; $display("FAIL b2b_word1: got %b/%h/%b want 1/%h/%b",
                            instr_valid[0], instr[0], fetch_fault[0], ew1, ef1);
      end
      @(negedge clk);
      checks++;
      if (instr_valid[0] !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: got valid %b want 0", instr_valid[0]);
      end
   endtask

   task automatic test_faults();
      int          tg   [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      logic [31:0] ta   [9] = '{32'h3FC, 32'h6, 32'hC, 32'h400,
                                32'h4FC, 32'h40, 32'h10C, 32'h500, 32'hFFFF_FFFC};
      logic [31:0] w, ew;
      logic        f, ef;
      int          lat;
      do_load(255, 32'hA5A5_0FF0);
      for (int i = 0; i < 9; i++) begin
         model(tg[i], ta[i], ew, ef);
         run_fetch(tg[i], ta[i], w, f, lat);
         checks++;
         if (w !== ew || f !== ef || lat != WS_TAB[tg[i]] + 1) begin
            errors++; $display("FAIL fault_tab[%0d] addr %h: got %h/%b lat %0d want %h/%b lat %0d",
                               i, ta[i], w, f, lat, ew, ef, WS_TAB[tg[i]] + 1);
         end
      end
   endtask

   task automatic test_wait_stall();
      logic [31:0] w, ew;
      logic        f, ef;
      int          lat;
      fetch_stall[2] = 1'b1;
      model(2, 32'h0, ew, ef);
      run_fetch(2, 32'h0, w, f, lat);
      checks++;
      if (lat != 4 || w !== ew || f !== ef) begin
         errors++; $display("FAIL ws3_fetch: got %h/%b lat %0d want %h/%b lat 4", w, f, lat, ew, ef);
      end
      repeat (5) begin
         @(negedge clk);
         #1;
         checks++;
         if (instr_valid[2] !== 1'b1 || instr[2] !== ew || fetch_ready[2] !== 1'b0) begin
            errors++; $display("FAIL stall_hold: got %b/%h ready %b want 1/%h ready 0",
                               instr_valid[2], instr[2], fetch_ready[2], ew);
         end
      end
      // Release the stall with load_mode up: result retires, port stays closed.
      load_mode[2]   = 1'b1;
      fetch_stall[2] = 1'b0;
      #1;
      checks++;
      if (fetch_ready[2] !== 1'b0 || instr_valid[2] !== 1'b1) begin
         errors++; $display("FAIL release_lm: got ready %b valid %b want 0 1", fetch_ready[2], instr_valid[2]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (instr_valid[2] !== 1'b0 || instr[2] !== ew || fetch_ready[2] !== 1'b0) begin
         errors++; $display("FAIL after_release: got %b/%h ready %b want 0/%h ready 0",
                            instr_valid[2], instr[2], fetch_ready[2], ew);
      end
      @(negedge clk);
      load_mode[2] = 1'b0;
   endtask

   task automatic test_load_mode_mid();
      logic [31:0] ew;
      logic        ef;
      int          lat;
      bit          seen;
      model(2, 32'hC, ew, ef);
      @(negedge clk);
      fetch_req[2]  = 1'b1;
      fetch_addr[2] = 32'hC;
      @(posedge clk);
      #1;
      load_mode[2] = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!instr_valid[2] && lat < 12);
      checks++;
      if (lat != 4 || instr[2] !== ew || fetch_fault[2] !== ef) begin
         errors++; $display("FAIL lm_mid_fetch: got %h/%b lat %0d want %h/%b lat 4",
                            instr[2], fetch_fault[2], lat, ew, ef);
      end
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (instr_valid[2] || fetch_ready[2]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL lm_no_accept: got accept activity want none");
      end
      fetch_req[2] = 1'b0;
      load_mode[2] = 1'b0;
   endtask

   task automatic test_rbw();
      logic [31:0] w, ew;
      logic        f, ef;
      int          lat;
      do_load(2, 32'h1111_2222);
      model(0, 32'h8, ew, ef);
      @(negedge clk);
      fetch_req[0]  = 1'b1;
      fetch_addr[0] = 32'h8;
      ld_we   = 1'b1;
      ld_addr = 8'd2;
      ld_data = 32'h2004_0003;
      @(posedge clk);
      #1;
      fetch_req[0] = 1'b0;
      ld_we        = 1'b0;
      ref_mem[2]    = 32'h2004_0003;
      ref_loaded[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid[0] !== 1'b1 || instr[0] !== ew) begin
         errors++; $display("FAIL rbw_old: got %b/%h want 1/%h", instr_valid[0], instr[0], ew);
      end
      model(0, 32'h8, ew, ef);
      run_fetch(0, 32'h8, w, f, lat);
      checks++;
      if (w !== ew || f !== ef) begin
         errors++; $display("FAIL rbw_new: got %h/%b want %h/%b", w, f, ew, ef);
      end
   endtask

   task automatic test_random();
      logic [31:0] w, ew, addr;
      logic        f, ef;
      int          lat, g;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_load(int'($urandom_range(0, WORDS - 1)), $urandom);
         end else begin
            g = int'($urandom_range(0, N - 1));
            case ($urandom_range(0, 3))
               0:       addr = $urandom;
               1:       addr = BASE_TAB[g] + 32'($urandom_range(250, 262)) * 4;
               default: addr = BASE_TAB[g] + 32'($urandom_range(0, WORDS - 1)) * 4;
            endcase
            model(g, addr, ew, ef);
            run_fetch(g, addr, w, f, lat);
            checks++;
            if (w !== ew || f !== ef || lat != WS_TAB[g] + 1) begin
               errors++; $display("FAIL rand[%0d] inst %0d addr %h: got %h/%b lat %0d want %h/%b lat %0d",
                                  i, g, addr, w, f, lat, ew, ef, WS_TAB[g] + 1);
            end
         end
      end
   endtask

   initial begin
      for (int g = 0; g < N; g++) fetch_addr[g] = '0;
      for (int i = 0; i < WORDS; i++) begin
         ref_mem[i]    = '0;
         ref_loaded[i] = 1'b0;
      end
      test_reset();
      test_reset_mid_wait();
      test_unloaded();
      test_load_run();
      test_faults();
      test_wait_stall();
      test_load_mode_mid();
      test_rbw();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
